fetch_unit: RTL

//  Instruction-fetch stage upstream of the decode/execute datapath: owns the program counter,

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, drives the IM address and
// registers each returned word into an IF/ID output with a valid/ready handshake.
// Ports: clk, asyn_n_rst, run, redirect_valid/redirect_addr in;
//        im_addr out, im_q in; instr/instr_pc/instr_valid out, instr_ready in; halted out.
// Option: define FETCH_HALT_EN to stop fetching after an all-ones word (HALT state).
module fetch_unit #(
  parameter int IM_ADDRESS_WIDTH  = 6,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter logic [IM_ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         asyn_n_rst,
  input  logic                         run,
  input  logic                         redirect_valid,
  input  logic [IM_ADDRESS_WIDTH-1:0]  redirect_addr,
  output logic [IM_ADDRESS_WIDTH-1:0]  im_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] im_q,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic [IM_ADDRESS_WIDTH-1:0]  instr_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic                         halted
);

  localparam logic [IM_ADDRESS_WIDTH-1:0] PC_ONE =
    IM_ADDRESS_WIDTH'(1);

  typedef struct packed {
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [IM_ADDRESS_WIDTH-1:0]  pc;
    logic                         valid;
  } if_id_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef FETCH_HALT_EN
    S_HALT  = 2'd2,
`endif
    S_FETCH = 2'd1
  } state_t;

  state_t                      state_q;
  state_t                      state_d;
  logic [IM_ADDRESS_WIDTH-1:0] pc_q;
  if_id_t                      out_q;

  logic slot_free;
  logic fire;
  logic halt_word;

  assign slot_free = !out_q.valid || instr_ready;

  // run gates fire so a FETCH->IDLE cycle never starts a new fetch.
  assign fire = (state_q == S_FETCH) && run &&
                slot_free && !redirect_valid;

`ifdef FETCH_HALT_EN
  assign halt_word = &im_q;
  assign halted    = (state_q == S_HALT);
`else
  assign halt_word = 1'b0;
  assign halted    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (!run)
          state_d = S_IDLE;
`ifdef FETCH_HALT_EN
        else if (fire && halt_word)
          state_d = S_HALT;
`endif
      end
`ifdef FETCH_HALT_EN
      S_HALT: begin
        if (redirect_valid)
          state_d = run ? S_FETCH : S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect flushes even a stalled word; otherwise fire
  // refills, or a plain accept empties the slot.
  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      pc_q  <= RESET_PC;
      out_q <= '0;
    end else if (redirect_valid) begin
      pc_q        <= redirect_addr;
      out_q.valid <= 1'b0;
    end else if (fire) begin
      out_q.instr <= im_q;
      out_q.pc    <= pc_q;
      out_q.valid <= 1'b1;
      if (!halt_word) pc_q <= pc_q + PC_ONE;
    end else if (out_q.valid && instr_ready) begin
      out_q.valid <= 1'b0;
    end
  end

  assign im_addr     = pc_q;
  assign instr       = out_q.instr;
  assign instr_pc    = out_q.pc;
  assign instr_valid = out_q.valid;

endmodule
